// File: rtl/jogador_pkg.sv
// Shared definitions for the memory-game auto-player: state codes, the
// expected play value of each index, and the one-bit rotation used to
// corrupt a play on purpose.
package jogador_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_PULSO         = 4'd1,
        ST_ESPERA        = 4'd2,
        ST_APLICA        = 4'd3,
        ST_INTERVALO     = 4'd4,
        ST_ESPERA_PRONTO = 4'd5,
        ST_FIM           = 4'd6
    } estado_t;

    // Rotate a 4-bit one-hot value left by one position (1000 wraps to 0001).
    function automatic logic [3:0] rotl1(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // Play i presses switch (i mod 4).
    function automatic logic [3:0] valor_esperado(input logic [3:0] idx);
        return 4'b0001 << idx[1:0];
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/jogador_automatico_exp4_contador.sv
// Loadable down-counter shared by every timed state of the auto-player.
// fim_o is high while the count sits at zero; a state that loads D-1 on
// entry therefore lasts exactly D cycles.
module contador_ciclos_jogador #(
    parameter int W = 12
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         carrega_i,
    input  logic [W-1:0] valor_i,
    input  logic         conta_i,
    output logic         fim_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; counting saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (carrega_i) begin
            cnt_d = valor_i;
        end else if (conta_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim_o = (cnt_q == '0);

endmodule

// File: rtl/jogador_automatico_exp4.sv
// Auto-player for the memory game: pulses iniciar_jogo, presses each play
// value on chaves with fixed hold/gap timing, optionally corrupts one play,
// and records the result the game reports (or a timeout).
//
// state          | code | meaning
// inicial        | 0    | idle after reset, waiting for iniciar
// pulso          | 1    | iniciar_jogo high for START_CYCLES
// espera         | 2    | chaves=0 for GAP_CYCLES before the first play
// aplica         | 3    | chaves = play value for HOLD_CYCLES
// intervalo      | 4    | chaves=0 for GAP_CYCLES after a play
// espera_pronto  | 5    | all plays done, waiting up to WAIT_MAX for pronto
// fim            | 6    | run finished, results held until next iniciar
module jogador_automatico_exp4
    import jogador_pkg::*;
#(
    parameter int START_CYCLES = 5,
    parameter int HOLD_CYCLES  = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int N_JOGADAS    = 16,
    parameter int WAIT_MAX     = 4000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       errar_en_i,
    input  logic [3:0] errar_em_i,
    input  logic       pronto_i,
    input  logic       acertou_i,
    input  logic       errou_i,
    output logic       iniciar_jogo_o,
    output logic [3:0] chaves_o,
    output logic       terminado_o,
    output logic       res_acerto_o,
    output logic       res_erro_o,
    output logic       res_timeout_o,
    output logic [3:0] db_jogada_o,
    output logic [3:0] db_estado_o
);

    localparam int CNT_MAX = max4(WAIT_MAX, HOLD_CYCLES, GAP_CYCLES, START_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CARGA_START = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] CARGA_HOLD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CARGA_GAP   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CARGA_WAIT  = CNT_W'(WAIT_MAX - 1);
    localparam logic [3:0]       ULTIMA      = 4'(N_JOGADAS - 1);

    estado_t    estado_q, estado_d;
    logic [3:0] idx_q, idx_d;
    logic       errar_en_q, errar_en_d;
    logic [3:0] errar_em_q, errar_em_d;
    logic       res_acerto_q, res_acerto_d;
    logic       res_erro_q, res_erro_d;
    logic       res_timeout_q, res_timeout_d;

    logic       iniciar_jogo_q, iniciar_jogo_d;
    logic [3:0] chaves_q, chaves_d;
    logic       terminado_q, terminado_d;

    logic             carrega;
    logic [CNT_W-1:0] valor;
    logic             cnt_fim;
    logic             captura;

    contador_ciclos_jogador #(
        .W(CNT_W)
    ) u_contador (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .carrega_i(carrega),
        .valor_i  (valor),
        .conta_i  (~carrega),
        .fim_o    (cnt_fim)
    );

    // State register together with the run context it owns.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q      <= ST_INICIAL;
            idx_q         <= '0;
            errar_en_q    <= 1'b0;
            errar_em_q    <= '0;
            res_acerto_q  <= 1'b0;
            res_erro_q    <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            idx_q         <= idx_d;
            errar_en_q    <= errar_en_d;
            errar_em_q    <= errar_em_d;
            res_acerto_q  <= res_acerto_d;
            res_erro_q    <= res_erro_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Next-state logic; a game report (pronto) wins over any timer expiry.
    always_comb begin
        estado_d      = estado_q;
        idx_d         = idx_q;
        errar_en_d    = errar_en_q;
        errar_em_d    = errar_em_q;
        res_acerto_d  = res_acerto_q;
        res_erro_d    = res_erro_q;
        res_timeout_d = res_timeout_q;
        carrega       = 1'b0;
        valor         = '0;

        captura = pronto_i && ((estado_q == ST_ESPERA) || (estado_q == ST_APLICA) ||
                               (estado_q == ST_INTERVALO) || (estado_q == ST_ESPERA_PRONTO));

        if (captura) begin
            estado_d     = ST_FIM;
            res_acerto_d = acertou_i;
            res_erro_d   = errou_i;
        end else begin
            case (estado_q)
                ST_INICIAL, ST_FIM: begin
                    if (iniciar_i) begin
                        estado_d      = ST_PULSO;
                        idx_d         = '0;
                        errar_en_d    = errar_en_i;
                        errar_em_d    = errar_em_i;
                        res_acerto_d  = 1'b0;
                        res_erro_d    = 1'b0;
                        res_timeout_d = 1'b0;
                        carrega       = 1'b1;
                        valor         = CARGA_START;
                    end
                end
                ST_PULSO: begin
                    if (cnt_fim) begin
                        estado_d = ST_ESPERA;
                        carrega  = 1'b1;
                        valor    = CARGA_GAP;
                    end
                end
                ST_ESPERA: begin
                    if (cnt_fim) begin
                        estado_d = ST_APLICA;
                        carrega  = 1'b1;
                        valor    = CARGA_HOLD;
                    end
                end
                ST_APLICA: begin
                    if (cnt_fim) begin
                        estado_d = ST_INTERVALO;
                        carrega  = 1'b1;
                        valor    = CARGA_GAP;
                    end
                end
                ST_INTERVALO: begin
                    if (cnt_fim) begin
                        carrega = 1'b1;
                        if (idx_q == ULTIMA) begin
                            estado_d = ST_ESPERA_PRONTO;
                            valor    = CARGA_WAIT;
                        end else begin
                            estado_d = ST_APLICA;
                            idx_d    = idx_q + 4'd1;
                            valor    = CARGA_HOLD;
                        end
                    end
                end
                ST_ESPERA_PRONTO: begin
                    if (cnt_fim) begin
                        estado_d      = ST_FIM;
                        res_timeout_d = 1'b1;
                    end
                end
                default: begin
                    estado_d = ST_INICIAL;
                end
            endcase
        end
    end

    // Output values for the state being entered, so they register on entry.
    always_comb begin
        iniciar_jogo_d = (estado_d == ST_PULSO);
        terminado_d    = (estado_d == ST_FIM);
        chaves_d       = '0;
        if (estado_d == ST_APLICA) begin
            if (errar_en_d && (errar_em_d == idx_d)) begin
                chaves_d = rotl1(valor_esperado(idx_d));
            end else begin
                chaves_d = valor_esperado(idx_d);
            end
        end
    end

    // Registered outputs; reset clears them without waiting for a clock.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            iniciar_jogo_q <= 1'b0;
            chaves_q       <= '0;
            terminado_q    <= 1'b0;
        end else begin
            iniciar_jogo_q <= iniciar_jogo_d;
            chaves_q       <= chaves_d;
            terminado_q    <= terminado_d;
        end
    end

    assign iniciar_jogo_o = iniciar_jogo_q;
    assign chaves_o       = chaves_q;
    assign terminado_o    = terminado_q;
    assign res_acerto_o   = res_acerto_q;
    assign res_erro_o     = res_erro_q;
    assign res_timeout_o  = res_timeout_q;
    assign db_jogada_o    = idx_q;
    assign db_estado_o    = estado_q;

endmodule

// File: tb/tb_jogador_automatico_exp4.sv
// Testbench for the memory-game auto-player. A timeline model derives, for
// each cycle after the start edge, what phase the run should be in; pronto
// truncates the timeline into fim when it lands in a result-capturing phase.
module tb_jogador_automatico_exp4;

    localparam int S     = 5;
    localparam int G     = 10;
    localparam int H     = 10;
    localparam int N     = 16;
    localparam int W     = 4000;
    localparam int P     = H + G;
    localparam int T_END = S + G + N * P + W;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       errar_en = 1'b0;
    logic [3:0] errar_em = 4'd0;
    logic       pronto = 1'b0;
    logic       acertou = 1'b0;
    logic       errou = 1'b0;
    logic       iniciar_jogo;
    logic [3:0] chaves;
    logic       terminado;
    logic       res_acerto;
    logic       res_erro;
    logic       res_timeout;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    jogador_automatico_exp4 #(
        .START_CYCLES(S),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .N_JOGADAS   (N),
        .WAIT_MAX    (W)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .iniciar_i     (iniciar),
        .errar_en_i    (errar_en),
        .errar_em_i    (errar_em),
        .pronto_i      (pronto),
        .acertou_i     (acertou),
        .errou_i       (errou),
        .iniciar_jogo_o(iniciar_jogo),
        .chaves_o      (chaves),
        .terminado_o   (terminado),
        .res_acerto_o  (res_acerto),
        .res_erro_o    (res_erro),
        .res_timeout_o (res_timeout),
        .db_jogada_o   (db_jogada),
        .db_estado_o   (db_estado)
    );

    typedef struct {
        int een;
        int eem;
        int p;      // cycle index whose preceding edge samples pronto=1; -1 never
        int ac;
        int er;
        int hold;   // cycles iniciar stays high from the start edge
        int x_fim;  // first cycle index showing fim
        int x_jog;
        int x_ac;
        int x_er;
        int x_to;
    } vec_t;

    vec_t tabela[8];

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
        end
    endtask

    function automatic int valor(input int i, input int een, input int eem);
        int b;
        b = 1 << (i % 4);
        if (een != 0 && i == eem) b = ((b << 1) | (b >> 3)) & 15;
        return b;
    endfunction

    // Phase of an undisturbed run at cycle k after the start edge.
    function automatic void fase(input int k, input int een, input int eem,
                                 output int st, output int idx, output int ch, output int ij);
        int m;
        st = 5; idx = N - 1; ch = 0; ij = 0;
        if (k < S) begin
            st = 1; idx = 0; ij = 1;
        end else if (k < S + G) begin
            st = 2; idx = 0;
        end else begin
            m = k - S - G;
            if (m < N * P) begin
                idx = m / P;
                if ((m % P) < H) begin
                    st = 3; ch = valor(idx, een, eem);
                end else begin
                    st = 4;
                end
            end
        end
    endfunction

    task automatic run(input vec_t v, input int stop, input bit resumo);
        int fim_entry, fim_idx, to, st, idx, ch, ij, last, obs_fim;
        int x_term, x_ac, x_er, x_to;
        fim_entry = T_END; fim_idx = N - 1; to = 1; obs_fim = -1;
        if (v.p >= 1 && v.p <= T_END) begin
            fase(v.p - 1, v.een, v.eem, st, idx, ch, ij);
            if (st >= 2 && st <= 5) begin
                fim_entry = v.p; fim_idx = idx; to = 0;
            end
        end
        last = (stop >= 0) ? stop : fim_entry + 3;
        @(negedge clock);
        iniciar  = 1'b1;
        errar_en = 1'(v.een);
        errar_em = 4'(v.eem);
        pronto   = 1'b0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            if (k < fim_entry) begin
                fase(k, v.een, v.eem, st, idx, ch, ij);
                x_term = 0; x_ac = 0; x_er = 0; x_to = 0;
            end else begin
                st = 6; idx = fim_idx; ch = 0; ij = 0; x_term = 1;
                x_ac = to ? 0 : v.ac; x_er = to ? 0 : v.er; x_to = to;
            end
            chk("estado", int'(db_estado), st);
            chk("jogada", int'(db_jogada), idx);
            chk("chaves", int'(chaves), ch);
            chk("iniciar_jogo", int'(iniciar_jogo), ij);
            chk("terminado", int'(terminado), x_term);
            chk("res_acerto", int'(res_acerto), x_ac);
            chk("res_erro", int'(res_erro), x_er);
            chk("res_timeout", int'(res_timeout), x_to);
            if (db_estado == 4'd6 && obs_fim < 0) obs_fim = k;
            iniciar  = (k + 1 < v.hold);
            errar_en = 1'($urandom);
            errar_em = 4'($urandom);
            pronto   = (k + 1 == v.p);
            acertou  = pronto ? 1'(v.ac) : 1'($urandom_range(0, 1));
            errou    = pronto ? 1'(v.er) : 1'($urandom_range(0, 1));
        end
        iniciar = 1'b0;
        pronto  = 1'b0;
        if (resumo) begin
            chk("tab_fim_entrada", obs_fim, v.x_fim);
            chk("tab_jogada_final", int'(db_jogada), v.x_jog);
            chk("tab_acerto", int'(res_acerto), v.x_ac);
            chk("tab_erro", int'(res_erro), v.x_er);
            chk("tab_timeout", int'(res_timeout), v.x_to);
        end
    endtask

    task automatic checa_inicial(input string nome);
        chk({nome, "_estado"}, int'(db_estado), 0);
        chk({nome, "_jogada"}, int'(db_jogada), 0);
        chk({nome, "_chaves"}, int'(chaves), 0);
        chk({nome, "_iniciar_jogo"}, int'(iniciar_jogo), 0);
        chk({nome, "_terminado"}, int'(terminado), 0);
        chk({nome, "_res"}, int'({res_acerto, res_erro, res_timeout}), 0);
    endtask

    initial begin
        vec_t v;
        //             een eem  p     ac er hold x_fim x_jog x_ac x_er x_to
        tabela[0] = '{0,  0,   330,  1, 0, 1,   330,  15,   1,   0,   0};  // success after last play
        tabela[1] = '{1,  3,   77,   0, 1, 1,   77,   3,    0,   1,   0};  // corrupted play 3
        tabela[2] = '{0,  0,   -1,   0, 0, 1,   T_END, 15,  0,   0,   1};  // timeout
        tabela[3] = '{0,  0,   135,  1, 1, 1,   135,  5,    1,   1,   0};  // pronto on intervalo expiry
        tabela[4] = '{0,  0,   10,   0, 0, 1,   10,   0,    0,   0,   0};  // pronto during espera
        tabela[5] = '{1,  15,  3,    1, 0, 200, T_END, 15,  0,   0,   1};  // pronto in pulso ignored
        tabela[6] = '{0,  0,   336,  1, 0, 1,   336,  15,   1,   0,   0};  // first espera_pronto cycle
        tabela[7] = '{1,  0,   T_END, 0, 1, 1,  T_END, 15,  0,   1,   0};  // pronto beats wait expiry

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checa_inicial("reset");
        end

        for (int i = 0; i < 8; i++) run(tabela[i], -1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            v.een  = $urandom_range(0, 1);
            v.eem  = $urandom_range(0, 15);
            v.p    = $urandom_range(6, 340);
            v.ac   = $urandom_range(0, 1);
            v.er   = $urandom_range(0, 1);
            v.hold = $urandom_range(1, 5);
            v.x_fim = 0; v.x_jog = 0; v.x_ac = 0; v.x_er = 0; v.x_to = 0;
            run(v, -1, 1'b0);
        end

        // Reset in the middle of play 2's aplica phase.
        v = '{0, 0, -1, 0, 0, 1, 0, 0, 0, 0, 0};
        run(v, S + G + 2 * P + 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_meio_chaves", int'(chaves), 0);
        chk("reset_meio_iniciar_jogo", int'(iniciar_jogo), 0);
        chk("reset_meio_estado", int'(db_estado), 0);
        @(negedge clock);
        reset   = 1'b0;
        iniciar = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checa_inicial("pos_reset");
        end

        run(tabela[4], -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jogador_automatico_exp4.md
Name: jogador_automatico_exp4

Overview:
- Hardware auto-player: the stimulus end of the memory-game interface (chaves/iniciar toward the game; pronto/acertou/errou back from it).
- Replaces manual switch play on the FPGA board. Presses each sequence value in order, with timing set by parameters.
- Can inject one deliberate error at a chosen play.
- Reports the outcome the game signals.

Parameters:
- START_CYCLES, 5, cycles iniciar_jogo is held high.
- HOLD_CYCLES, 10, cycles each play is held on chaves.
- GAP_CYCLES, 10, cycles of chaves=0 after the start pulse and after each play.
- N_JOGADAS, 16, plays in a full sequence (1..16).
- WAIT_MAX, 4000, cycles to wait for pronto after the last play before declaring timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  level; starts a run from inicial or fim
- errar_en  in  1  enable error injection (sampled when the run starts)
- errar_em  in  4  play index (0-based) to corrupt (sampled when the run starts)
- pronto  in  1  game finished
- acertou  in  1  game result: success
- errou  in  1  game result: error
- iniciar_jogo  out  1  start pulse to the game
- chaves  out  4  one-hot play value to the game
- terminado  out  1  run finished
- res_acerto  out  1  game reported acertou
- res_erro  out  1  game reported errou
- res_timeout  out  1  no pronto within WAIT_MAX
- db_jogada  out  4  current play index
- db_estado  out  4  state code

Behaviour:
- Reset (async, active-high): state inicial; all outputs 0; index 0; counters 0. Asserting reset mid-run forces chaves=0 and iniciar_jogo=0 immediately.
- Expected sequence: value of play i = 4'b0001 << (i mod 4).
  - Corrupted value = expected rotated left by 1 (e.g. 0100 -> 1000, 1000 -> 0001).
  - Corruption applies only when errar_en=1 and i==errar_em, using the values latched at the run start.
- States and codes, with transitions:
  - inicial 0: outputs 0. iniciar=1 -> latch errar_en/errar_em, clear res_*, index=0 -> pulso.
  - pulso 1: iniciar_jogo=1 for exactly START_CYCLES cycles -> espera.
  - espera 2: chaves=0 for GAP_CYCLES cycles -> aplica.
  - aplica 3: chaves = value(index) for exactly HOLD_CYCLES cycles -> intervalo.
  - intervalo 4: chaves=0 for GAP_CYCLES cycles. Then index==N_JOGADAS-1 -> espera_pronto; otherwise index+1 -> aplica.
  - espera_pronto 5: chaves=0; counts up to WAIT_MAX cycles. Expiry -> fim with res_timeout=1.
  - fim 6: terminado=1; res_* held; chaves=0. iniciar=1 -> restart as from inicial.
- Result capture: in states 2–5, pronto=1 sampled on a clock edge -> next state fim.
  - res_acerto <= acertou and res_erro <= errou at that same edge.
  - pronto has priority over any counter expiry in the same cycle.
  - If acertou and errou are both 1, both flags are set.
- Outputs are registered. chaves changes only on clock edges, at state entry.
- db_jogada = index, 0..N_JOGADAS-1, no wrap. db_estado = state code.
- iniciar held high through a run has no effect until fim.

Decomposition:
- Package jogador_pkg:
  - state encoding constants (values 0–6);
  - rotl1 function on 4 bits;
  - expected-value function of the index.
- One sub-module: contador_ciclos_jogador.
  - Loadable down-counter, width sized for max(WAIT_MAX, HOLD_CYCLES, GAP_CYCLES, START_CYCLES).
  - Ports: clock, reset, carrega, valor, conta, fim.
  - Shared by all timed states.

Test Plan:
- Reset for 1 cycle, then idle 10 cycles -> all outputs 0, db_estado=0.
- iniciar=1, errar_en=0, game model replies pronto+acertou 5 cycles after play 15 ends:
  - iniciar_jogo high exactly 5 cycles;
  - chaves sequence 0001,0010,0100,1000 repeated, each value held 10 cycles with 10-cycle gaps;
  - terminado=1, res_acerto=1.
- errar_en=1, errar_em=3, game model asserts pronto+errou 2 cycles after the play-3 value appears:
  - play 3 chaves=0001 instead of 1000;
  - fim entered with res_erro=1, db_jogada=3;
  - no play 4 is issued.
- Game model never asserts pronto -> after play 15 plus gap, exactly 4000 cycles elapse, then res_timeout=1, terminado=1.
- Reset asserted during the aplica state of play 2 -> chaves=0 without waiting for a clock edge; after release, db_estado=0 and no further plays until iniciar.
- pronto asserted on the cycle the intervalo counter expires -> fim entered; index not incremented.
